// File: rtl/pulse_gen_pkg.sv
// Shared types, reset defaults and the effective-width rule for the pulse generator.
package pulse_gen_pkg;

  // Encoding chosen so busy is state[1] and pulse is state[0].
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOW  = 2'b10,
    HIGH = 2'b11
  } state_t;

  localparam int DEF_PERIOD = 24;
  localparam int DEF_WIDTH  = 5;

  // High time actually produced: width clamped so at least one low cycle remains.
  // Zero means the channel cannot start.
  function automatic int unsigned eff_width(input int unsigned period,
                                            input int unsigned width);
    if (period <= 1 || width == 0) begin
      return 0;
    end else if (width < period) begin
      return width;
    end else begin
      return period - 1;
    end
  endfunction

endpackage

// File: rtl/pulse_gen_chan.sv
// One pulse channel: config registers, active (latched) timing, IDLE/HIGH/LOW FSM.
module pulse_gen_chan #(
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = 24,
  parameter int DEF_WIDTH  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic             cfg_oneshot,
  input  logic             en,
  input  logic             trig,
  output logic             pulse,
  output logic             busy
);
  import pulse_gen_pkg::*;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] period_reg, width_reg;
  logic             oneshot_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] low_len_reg, low_len_next;
  logic             mode_os_reg, mode_os_next;
  logic [CNT_W-1:0] start_we;

  // Effective width from the programmed (not yet latched) config.
  assign start_we = CNT_W'(eff_width(32'(period_reg), 32'(width_reg)));

  // Programmed config; running timing is only taken from here on HIGH entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_reg  <= CNT_W'(DEF_PERIOD);
      width_reg   <= CNT_W'(DEF_WIDTH);
      oneshot_reg <= 1'b0;
    end else if (cfg_wr) begin
      period_reg  <= cfg_period;
      width_reg   <= cfg_width;
      oneshot_reg <= cfg_oneshot;
    end
  end

  // State, down-counter and latched timing of the current pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      low_len_reg <= '0;
      mode_os_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      low_len_reg <= low_len_next;
      mode_os_reg <= mode_os_next;
    end
  end

  // Next state: cnt holds the remaining cycles of the current state minus one.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    low_len_next = low_len_reg;
    mode_os_next = mode_os_reg;
    case (state_reg)
      IDLE: begin
        if (en && start_we != '0 && (!oneshot_reg || trig)) begin
          state_next   = HIGH;
          cnt_next     = start_we - ONE;
          low_len_next = period_reg - start_we;
          mode_os_next = oneshot_reg;
        end
      end
      HIGH: begin
        if (!en) begin
          state_next = IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - ONE;
        end else if (mode_os_reg) begin
          state_next = IDLE;
        end else begin
          state_next = LOW;
          cnt_next   = low_len_reg - ONE;
        end
      end
      LOW: begin
        if (!en) begin
          state_next = IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - ONE;
        end else if (start_we != '0) begin
          state_next   = HIGH;
          cnt_next     = start_we - ONE;
          low_len_next = period_reg - start_we;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded directly from the state register bits.
  always_comb begin
    pulse = (state_reg == HIGH);
    busy  = (state_reg != IDLE);
  end

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse generator: config write decode plus CHANNELS independent channels.
module pulse_gen_multi #(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = pulse_gen_pkg::DEF_PERIOD,
  parameter int DEF_WIDTH  = pulse_gen_pkg::DEF_WIDTH,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_width,
  input  logic                cfg_oneshot,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] trig,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] busy
);
  import pulse_gen_pkg::*;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic wr;

    // Indices with no matching channel never match, so such writes are dropped.
    assign wr = cfg_we && (cfg_ch == CH_W'(gi));

    pulse_gen_chan #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_WIDTH  (DEF_WIDTH)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_wr      (wr),
      .cfg_period  (cfg_period),
      .cfg_width   (cfg_width),
      .cfg_oneshot (cfg_oneshot),
      .en          (en[gi]),
      .trig        (trig[gi]),
      .pulse       (pulse[gi]),
      .busy        (busy[gi])
    );
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Scoreboard bench for pulse_gen_multi against a phase-position reference model.
module tb_pulse_gen_multi;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [7:0]     cfg_period;
  logic [7:0]     cfg_width;
  logic           cfg_oneshot;
  logic [NCH-1:0] en;
  logic [NCH-1:0] trig;
  logic [NCH-1:0] pulse;
  logic [NCH-1:0] busy;

  pulse_gen_multi #(
    .CHANNELS   (NCH),
    .CNT_W      (8),
    .DEF_PERIOD (24),
    .DEF_WIDTH  (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_width   (cfg_width),
    .cfg_oneshot (cfg_oneshot),
    .en          (en),
    .trig        (trig),
    .pulse       (pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] pulse;
    logic [NCH-1:0] busy;
    int             cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: each running channel is a position within its current period.
  int m_cp[NCH], m_cw[NCH];
  bit m_cos[NCH];
  bit m_act[NCH], m_osa[NCH];
  int m_pos[NCH], m_per[NCH], m_we[NCH];

  function automatic int eff(input int p, input int w);
    if (p <= 1 || w == 0) return 0;
    return (w < p) ? w : p - 1;
  endfunction

  function automatic void model_step();
    int w;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_cp[c] = 24; m_cw[c] = 5; m_cos[c] = 0;
        m_act[c] = 0; m_osa[c] = 0; m_pos[c] = 0; m_per[c] = 0; m_we[c] = 0;
      end
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      if (m_act[c]) begin
        if (!en[c]) begin
          m_act[c] = 0;
        end else begin
          m_pos[c]++;
          if (m_osa[c] && m_pos[c] == m_we[c]) begin
            m_act[c] = 0;
          end else if (m_pos[c] == m_per[c]) begin
            w = eff(m_cp[c], m_cw[c]);
            if (w == 0) m_act[c] = 0;
            else begin m_per[c] = m_cp[c]; m_we[c] = w; m_pos[c] = 0; end
          end
        end
      end else begin
        w = eff(m_cp[c], m_cw[c]);
        if (en[c] && w != 0 && (!m_cos[c] || trig[c])) begin
          m_act[c] = 1; m_pos[c] = 0; m_per[c] = m_cp[c]; m_we[c] = w; m_osa[c] = m_cos[c];
        end
      end
    end
    if (cfg_we) begin
      m_cp[cfg_ch]  = int'(cfg_period);
      m_cw[cfg_ch]  = int'(cfg_width);
      m_cos[cfg_ch] = cfg_oneshot;
    end
  endfunction

  // Predict the outputs following the next edge, queue them, then advance one cycle.
  task automatic tick();
    exp_t e;
    model_step();
    for (int c = 0; c < NCH; c++) begin
      e.pulse[c] = m_act[c] && (m_pos[c] < m_we[c]);
      e.busy[c]  = m_act[c];
    end
    e.cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg_write(input int ch, input int p, input int w, input bit os);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = 8'(p); cfg_width = 8'(w); cfg_oneshot = os;
    $display("[TB] cyc=%0d cfg ch=%0d period=%0d width=%0d oneshot=%0d", cyc, ch, p, w, os);
    tick();
    cfg_we = 1'b0;
  endtask

  // Advance until the model shows channel c at position pos of a running pulse.
  task automatic wait_pos(input int c, input int pos);
    for (int i = 0; i < 300; i++) begin
      if (m_act[c] && m_pos[c] == pos) return;
      tick();
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_pos ch=%0d: position %0d not reached within 300 cycles, required reached", c, pos);
  endtask

  // Monitor: compare DUT outputs just after every edge with the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (pulse !== e.pulse || busy !== e.busy) begin
          n_fail++;
          $display("FAIL pulse_busy cyc=%0d got pulse=%b busy=%b required pulse=%b busy=%b",
                   e.cyc, pulse, busy, e.pulse, e.busy);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_width = '0;
    cfg_oneshot = 1'b0; en = '0; trig = '0;
    @(negedge clk);

    // Reset state
    run(3);
    rst_n = 1'b1;
    run(2);

    // Defaults on ch0 over 10 periods
    en[0] = 1'b1;
    run(245);

    // ch1 width clamp: period 4, width 9
    cfg_write(1, 4, 9, 0);
    en[1] = 1'b1;
    run(20);

    // ch2 one-shot with single trig, then trig during pulse
    cfg_write(2, 10, 3, 1);
    en[2] = 1'b1;
    run(2);
    trig[2] = 1'b1; tick(); trig[2] = 1'b0;
    tick();
    trig[2] = 1'b1; tick(); trig[2] = 1'b0;
    run(10);

    // ch0 width rewrite mid-HIGH, then en drop mid-HIGH
    wait_pos(0, 1);
    cfg_write(0, 24, 2, 0);
    run(60);
    wait_pos(0, 0);
    en[0] = 1'b0;
    run(5);

    // Reset while everything runs; defaults must return
    en = 4'b1111;
    trig = 4'b0100;
    run(30);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    trig = '0;
    run(60);

    // Degenerate configs on ch3
    cfg_write(3, 1, 5, 0);
    run(40);
    cfg_write(3, 10, 0, 0);
    run(30);

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 8) en[$urandom_range(0, NCH-1)] ^= 1'b1;
      trig = NCH'($urandom);
      rst_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 15) == 0) begin
        cfg_write($urandom_range(0, NCH-1), $urandom_range(0, 30),
                  $urandom_range(0, 12), 1'($urandom_range(0, 1)));
      end else begin
        tick();
      end
    end
    rst_n = 1'b1;
    en = '0;
    trig = '0;
    run(3);

    // Every prediction must have been consumed by the monitor
    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending entries required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
